// File: rtl/aes_sbox_pkg.sv
// Shared types and the AES S-box table for the unmask checker.
// Latency: n/a (package; sbox() is purely combinational).
// Backpressure: n/a.
package aes_sbox_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Forward AES SubBytes table, indexed by the input byte
    localparam logic [7:0] SBOX_TAB [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] i_x);
        return SBOX_TAB[i_x];
    endfunction

endpackage

// File: rtl/sbox_ref_delay.sv
// Alignment line: carries {valid, reference byte} alongside the S-box pipeline.
// Latency: LATENCY cycles from i_dat to o_dat.
// Backpressure: none; shifts every cycle, i_clr empties every stage.
module sbox_ref_delay #(
    parameter int WIDTH   = 9,
    parameter int LATENCY = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_dat,
    output logic [WIDTH-1:0] o_dat
);

    logic [WIDTH-1:0] r_stage [LATENCY];

    // Shift register; reset and clear both drop every in-flight entry
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            for (int k = 0; k < LATENCY; k++) r_stage[k] <= '0;
        end else begin
            r_stage[0] <= i_dat;
            for (int k = 1; k < LATENCY; k++) r_stage[k] <= r_stage[k-1];
        end
    end

    assign o_dat = r_stage[LATENCY-1];

endmodule

// File: rtl/aes_sbox_unmask_checker.sv
// Recombines masked S-box output shares and checks them against SubBytes of the delayed reference.
// Latency: input at t is compared at t+LATENCY, result registered and visible at t+LATENCY+1.
// Backpressure: none; accepts one compare per cycle, inputs outside RUN are dropped.
module aes_sbox_unmask_checker
    import aes_sbox_pkg::*;
#(
    parameter int SHARES     = 2,
    parameter int LATENCY    = 4,
    parameter int NUM_CHECKS = 256
) (
    input  logic                ClkxCI,
    input  logic                RstxRI,
    input  logic                StartxSI,
    input  logic                ValidInxSI,
    input  logic [7:0]          XrefxDI,
    input  logic [8*SHARES-1:0] _QxDI,
    output logic                ValidOutxSO,
    output logic [7:0]          QxDO,
    output logic                ErrorxSO,
    output logic [CNT_W-1:0]    ErrCntxDO,
    output logic [CNT_W-1:0]    ChkCntxDO,
    output logic                DonexSO,
    output logic                PassxSO
);

    localparam logic [CNT_W-1:0] NUM_CHK  = CNT_W'(NUM_CHECKS);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;

    state_e           r_state, w_state_nxt;
    logic [8:0]       w_line_in, w_line_out;
    logic             w_last_vld;
    logic [7:0]       w_last_ref, w_recomb, w_expected;
    logic             w_fire, w_enter_done, w_clr, w_mismatch;
    logic [CNT_W-1:0] w_chk_inc;
    logic [CNT_W-1:0] r_err_cnt, r_chk_cnt;
    logic             r_vld_out, r_err;
    logic [7:0]       r_q;

    // Only inputs applied while running enter the alignment line
    assign w_line_in  = {ValidInxSI & (r_state == RUN), XrefxDI};
    assign w_last_vld = w_line_out[8];
    assign w_last_ref = w_line_out[7:0];
    assign w_clr      = StartxSI | w_enter_done;

    sbox_ref_delay #(
        .WIDTH   (9),
        .LATENCY (LATENCY)
    ) u_ref_delay (
        .i_clk (ClkxCI),
        .i_rst (RstxRI),
        .i_clr (w_clr),
        .i_dat (w_line_in),
        .o_dat (w_line_out)
    );

    // XOR fold of all output shares, one byte per share
    for (genvar g = 0; g < SHARES; g++) begin : g_xor
        logic [7:0] w_acc;
        if (g == 0) begin : g_first
            assign w_acc = _QxDI[7:0];
        end else begin : g_next
            assign w_acc = g_xor[g-1].w_acc ^ _QxDI[8*g +: 8];
        end
    end

    assign w_recomb   = g_xor[SHARES-1].w_acc;
    assign w_expected = sbox(w_last_ref);
    assign w_mismatch = (w_recomb != w_expected);
    assign w_chk_inc  = r_chk_cnt + 1'b1;

    // State register
    always_ff @(posedge ClkxCI) begin
        if (RstxRI) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state and compare strobe; a start always restarts and suppresses the compare
    always_comb begin
        w_state_nxt  = r_state;
        w_fire       = 1'b0;
        w_enter_done = 1'b0;
        case (r_state)
            IDLE: if (StartxSI) w_state_nxt = RUN;
            RUN: begin
                if (StartxSI) begin
                    w_state_nxt = RUN;
                end else if (w_last_vld) begin
                    w_fire = 1'b1;
                    if (w_chk_inc == NUM_CHK) begin
                        w_state_nxt  = DONE;
                        w_enter_done = 1'b1;
                    end
                end
            end
            DONE: if (StartxSI) w_state_nxt = RUN;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Compare result registers and counters
    always_ff @(posedge ClkxCI) begin
        if (RstxRI) begin
            r_vld_out <= 1'b0;
            r_err     <= 1'b0;
            r_q       <= 8'h00;
            r_err_cnt <= '0;
            r_chk_cnt <= '0;
        end else begin
            r_vld_out <= w_fire;
            r_err     <= w_fire & w_mismatch;
            if (w_fire) r_q <= w_recomb;
            if (StartxSI) begin
                r_err_cnt <= '0;
                r_chk_cnt <= '0;
            end else if (w_fire) begin
                r_chk_cnt <= w_chk_inc;
                if (w_mismatch && (r_err_cnt != CNT_SAT)) r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign ValidOutxSO = r_vld_out;
    assign ErrorxSO    = r_err;
    assign QxDO        = r_q;
    assign ErrCntxDO   = r_err_cnt;
    assign ChkCntxDO   = r_chk_cnt;
    assign DonexSO     = (r_state == DONE);
    assign PassxSO     = (r_state == DONE) && (r_err_cnt == '0);

endmodule

// File: tb/tb_aes_sbox_unmask_checker.sv
// Bench for the S-box unmask checker: GF(2^8)-derived S-box model plus a due-time queue model.
// Latency: checks outputs every cycle at the falling edge.
// Backpressure: n/a.
module tb_aes_sbox_unmask_checker;

    localparam int L = 4;
    localparam int N = 256;

    logic        clk, rst;
    logic        start, vin;
    logic [7:0]  xref;
    logic [15:0] shares;
    logic        vout, err, done, pass;
    logic [7:0]  q;
    logic [15:0] errcnt, chkcnt;

    logic        start3, vin3;
    logic [7:0]  x3;
    logic [23:0] sh3;
    logic        vout3, err3, done3, pass3;
    logic [7:0]  q3;
    logic [15:0] errcnt3, chkcnt3;

    aes_sbox_unmask_checker #(.SHARES(2), .LATENCY(L), .NUM_CHECKS(N)) u_dut (
        .ClkxCI(clk), .RstxRI(rst), .StartxSI(start), .ValidInxSI(vin), .XrefxDI(xref),
        ._QxDI(shares), .ValidOutxSO(vout), .QxDO(q), .ErrorxSO(err), .ErrCntxDO(errcnt),
        .ChkCntxDO(chkcnt), .DonexSO(done), .PassxSO(pass)
    );

    aes_sbox_unmask_checker #(.SHARES(3), .LATENCY(8), .NUM_CHECKS(4)) u_dut3 (
        .ClkxCI(clk), .RstxRI(rst), .StartxSI(start3), .ValidInxSI(vin3), .XrefxDI(x3),
        ._QxDI(sh3), .ValidOutxSO(vout3), .QxDO(q3), .ErrorxSO(err3), .ErrCntxDO(errcnt3),
        .ChkCntxDO(chkcnt3), .DonexSO(done3), .PassxSO(pass3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // S-box model: multiplicative inverse in GF(2^8) followed by the AES affine map
    logic [7:0] sbox_t [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    // Reference model: pending compares keyed by the cycle they fall due
    typedef struct {
        int         due;
        logic [7:0] x;
        logic [7:0] flip;
    } pend_t;

    pend_t      pq[$];
    int         m_state;   // 0 idle, 1 run, 2 done
    logic       m_vout, m_err;
    logic [7:0] m_q;
    int         m_chk, m_err_cnt;
    int         cyc = 0;

    wire [43:0] dut_vec = {vout, err, q, errcnt, chkcnt, done, pass};

    function automatic logic [43:0] exp_vec();
        return {m_vout, m_err, m_q, 16'(m_err_cnt), 16'(m_chk), m_state == 2,
                (m_state == 2) && (m_err_cnt == 0)};
    endfunction

    // One cycle on the main DUT: drive inputs/shares, advance the model, wait past the edge
    task automatic step(input logic st, input logic vi, input logic [7:0] x, input logic [7:0] fl);
        logic [7:0] m, s0, rec;
        logic       fire;
        m = 8'($urandom);
        if (pq.size() > 0 && pq[0].due == cyc) s0 = sbox_t[pq[0].x] ^ pq[0].flip ^ m;
        else                                   s0 = 8'($urandom);
        shares = {m, s0};
        start  = st;
        vin    = vi;
        xref   = x;
        rec    = s0 ^ m;
        fire   = 1'b0;
        if (st) begin
            m_state = 1; m_chk = 0; m_err_cnt = 0; pq.delete();
            m_vout = 1'b0; m_err = 1'b0;
        end else begin
            if (m_state == 1 && pq.size() > 0 && pq[0].due == cyc) begin
                fire   = 1'b1;
                m_vout = 1'b1;
                m_q    = rec;
                m_err  = (rec != sbox_t[pq[0].x]);
                m_chk++;
                if (m_err && m_err_cnt < 65535) m_err_cnt++;
                void'(pq.pop_front());
            end else begin
                m_vout = 1'b0; m_err = 1'b0;
            end
            if (m_state == 1 && vi) pq.push_back(pend_t'{cyc + L, x, fl});
            if (fire && m_chk == N) begin
                m_state = 2; pq.delete();
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset(input logic st);
        rst = 1'b1; start = st; vin = 1'b1; xref = 8'($urandom); shares = 16'($urandom);
        @(negedge clk);
        rst = 1'b0; start = 1'b0; vin = 1'b0;
        pq.delete(); m_state = 0; m_vout = 1'b0; m_err = 1'b0; m_q = 8'h00;
        m_chk = 0; m_err_cnt = 0;
        cyc++;
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        tests++; if (dut_vec !== exp_vec()) begin fails++; $display("FAIL reset_main got=%h exp=%h", dut_vec, exp_vec()); end
        tests++; if (dut_vec !== 44'h0) begin fails++; $display("FAIL reset_zero got=%h exp=0", dut_vec); end
        tests++;
        if ({vout3, err3, q3, errcnt3, chkcnt3, done3, pass3} !== 44'h0) begin
            fails++; $display("FAIL reset_dut3 got=%h exp=0", {vout3, err3, q3, errcnt3, chkcnt3, done3, pass3});
        end
    endtask

    task automatic test_three_shares();
        logic [7:0] a, b;
        start3 = 1'b1; step(0, 0, 8'h00, 8'h00); start3 = 1'b0;
        vin3 = 1'b1; x3 = 8'hff; sh3 = 24'($urandom); step(0, 0, 8'h00, 8'h00); vin3 = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (i == 8) begin
                a = 8'($urandom); b = 8'($urandom);
                sh3 = {b, a, 8'h16 ^ a ^ b};
            end else begin
                sh3 = 24'($urandom);
            end
            step(0, 0, 8'h00, 8'h00);
            if (i < 8) begin
                tests++; if (vout3 !== 1'b0) begin fails++; $display("FAIL three_early i=%0d got=%b exp=0", i, vout3); end
            end else begin
                tests++;
                if ({vout3, err3, q3, chkcnt3} !== {1'b1, 1'b0, 8'h16, 16'd1}) begin
                    fails++; $display("FAIL three_cmp got v=%b e=%b q=%h c=%0d exp v=1 e=0 q=16 c=1", vout3, err3, q3, chkcnt3);
                end
            end
        end
    endtask

    task automatic test_basic();
        logic [7:0] xs [3];
        logic [7:0] seen[$];
        int t0, first_rel;
        xs[0] = 8'h00; xs[1] = 8'h01; xs[2] = 8'h53;
        first_rel = -1;
        step(1, 0, 8'h00, 8'h00);
        tests++; if (dut_vec !== exp_vec()) begin fails++; $display("FAIL basic_start got=%h exp=%h", dut_vec, exp_vec()); end
        t0 = cyc;
        for (int i = 0; i < 3 + L + 3; i++) begin
            if (i < 3) step(0, 1, xs[i], 8'h00);
            else       step(0, 0, 8'($urandom), 8'h00);
            tests++; if (dut_vec !== exp_vec()) begin fails++; $display("FAIL basic cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec()); end
            if (vout) begin
                seen.push_back(q);
                if (first_rel < 0) first_rel = cyc - t0;
            end
        end
        tests++; if (first_rel !== L + 1) begin fails++; $display("FAIL basic_latency got=%0d exp=%0d", first_rel, L + 1); end
        tests++;
        if (seen.size() != 3 || seen[0] !== 8'h63 || seen[1] !== 8'h7c || seen[2] !== 8'hed) begin
            fails++; $display("FAIL basic_bytes got n=%0d exp 63,7c,ed", seen.size());
        end
        tests++; if (chkcnt !== 16'd3) begin fails++; $display("FAIL basic_chk got=%0d exp=3", chkcnt); end
    endtask

    task automatic test_error();
        logic [7:0] xs [3];
        logic [7:0] err_q;
        int nerr;
        xs[0] = 8'h00; xs[1] = 8'h01; xs[2] = 8'h53;
        nerr = 0; err_q = 8'h00;
        step(1, 0, 8'h00, 8'h00);
        for (int i = 0; i < 3 + L + 3; i++) begin
            if (i < 3) step(0, 1, xs[i], (i == 1) ? 8'h01 : 8'h00);
            else       step(0, 0, 8'h00, 8'h00);
            tests++; if (dut_vec !== exp_vec()) begin fails++; $display("FAIL error cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec()); end
            if (err) begin nerr++; err_q = q; end
        end
        tests++;
        if (nerr != 1 || err_q !== 8'h7d || errcnt !== 16'd1) begin
            fails++; $display("FAIL error_pulse got n=%0d q=%h cnt=%0d exp n=1 q=7d cnt=1", nerr, err_q, errcnt);
        end
    endtask

    task automatic test_random();
        logic [7:0] fl;
        step(1, 0, 8'h00, 8'h00);
        for (int i = 0; i < 120; i++) begin
            fl = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), 8'($urandom), fl);
            tests++; if (dut_vec !== exp_vec()) begin fails++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec()); end
        end
    endtask

    task automatic test_restart();
        step(1, 0, 8'h00, 8'h00);
        for (int i = 0; i < 20 + L + 2; i++) begin
            if (i < 20) step((i == 10), 1, 8'($urandom), 8'h00);
            else        step(0, 0, 8'h00, 8'h00);
            tests++; if (dut_vec !== exp_vec()) begin fails++; $display("FAIL restart cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec()); end
            if (i == 10) begin
                tests++;
                if (chkcnt !== 16'd0 || errcnt !== 16'd0 || vout !== 1'b0) begin
                    fails++; $display("FAIL restart_clear got chk=%0d err=%0d v=%b exp 0,0,0", chkcnt, errcnt, vout);
                end
            end
        end
    endtask

    task automatic test_sweep();
        step(1, 0, 8'h00, 8'h00);
        for (int i = 0; i < N + 1 + L + 2; i++) begin
            if (i <= N) step(0, 1, 8'(i), 8'h00);
            else        step(0, 0, 8'h00, 8'h00);
            tests++; if (dut_vec !== exp_vec()) begin fails++; $display("FAIL sweep cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec()); end
        end
        tests++;
        if ({done, pass, chkcnt} !== {1'b1, 1'b1, 16'd256}) begin
            fails++; $display("FAIL sweep_done got d=%b p=%b chk=%0d exp 1,1,256", done, pass, chkcnt);
        end
    endtask

    task automatic test_reset_midrun();
        step(1, 0, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) step(0, 1, 8'($urandom), 8'h00);
        do_reset(1'b1);
        tests++; if (dut_vec !== 44'h0) begin fails++; $display("FAIL midrun_reset got=%h exp=0", dut_vec); end
        for (int i = 0; i < L + 3; i++) begin
            step(0, 1, 8'($urandom), 8'h00);
            tests++; if (dut_vec !== exp_vec()) begin fails++; $display("FAIL midrun_idle cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec()); end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; vin = 1'b0; xref = 8'h00; shares = 16'h0;
        start3 = 1'b0; vin3 = 1'b0; x3 = 8'h00; sh3 = 24'h0;
        m_state = 0; m_vout = 1'b0; m_err = 1'b0; m_q = 8'h00; m_chk = 0; m_err_cnt = 0;
        build_sbox();
        @(negedge clk);
        test_reset();
        test_three_shares();
        test_basic();
        test_error();
        test_random();
        test_restart();
        test_sweep();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
